// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the boot-time RAM loader.
package ram_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_CHECK,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_FIN
  } state_t;

  // States in which the loader consumes a stream byte.
  function automatic logic rx_state(input state_t s);
    return (s == ST_LEN_HI)  || (s == ST_LEN_LO)  ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
           (s == ST_CSUM_HI) || (s == ST_CSUM_LO);
  endfunction

endpackage

// File: rtl/ram_loader_csum.sv
// Running mod-2^16 sum of written words and compare against the received checksum.
module ram_loader_csum
  import ram_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                add_en,
  input  logic [2*BYTE_W-1:0] add_word,
  input  logic [2*BYTE_W-1:0] chk_word,
  output logic                mismatch
);

  logic [2*BYTE_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + add_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign mismatch = (acc_q != chk_word);

endmodule

// File: rtl/ram_loader.sv
// Boot-time loader: byte stream -> big-endian 16-bit words -> consecutive RAM writes.
// Optional trailing checksum verification is enabled by defining RAM_LOADER_CSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start
// LEN_HI  | word count, high byte
// LEN_LO  | word count, low byte
// CHECK   | range check of base+N, no byte taken
// DATA_HI | data word, high byte
// DATA_LO | data word, low byte; write issued next cycle
// CSUM_HI | checksum, high byte
// CSUM_LO | checksum, low byte; compare
// FIN     | done pulse, release RAM
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA = 16,
  parameter int ADDR = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR-1:0]   base_addr,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              ram_wr,
  output logic [ADDR-1:0]   ram_addr,
  output logic [DATA-1:0]   ram_din,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int SW = ((ADDR > 16) ? ADDR : 16) + 1;
  localparam logic [SW-1:0] LIMIT = SW'(1) << ADDR;
`ifdef RAM_LOADER_CSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM_HI;
`else
  localparam state_t ST_AFTER_DATA = ST_FIN;
`endif

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [2*BYTE_W-1:0] cnt_q, cnt_d;
  logic [ADDR-1:0]     waddr_q, waddr_d;
  logic                s_ready_q, s_ready_d;
  logic                ram_wr_q, ram_wr_d;
  logic [ADDR-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA-1:0]     ram_din_q, ram_din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                hs;
  logic                ovf;
  logic [SW-1:0]       end_sum;
  logic [DATA-1:0]     word;

  assign hs      = s_valid && s_ready_q;
  assign word    = {byte_q, s_data};
  // waddr_q still holds the base address while in CHECK.
  assign end_sum = SW'(waddr_q) + SW'(cnt_q);
  assign ovf     = (end_sum > LIMIT);

`ifdef RAM_LOADER_CSUM_EN
  logic csum_bad;

  ram_loader_csum u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      ((state_q == ST_IDLE) && start),
    .add_en   ((state_q == ST_DATA_LO) && hs),
    .add_word (word),
    .chk_word (word),
    .mismatch (csum_bad)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      cnt_q      <= '0;
      waddr_q    <= '0;
      s_ready_q  <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      s_ready_q  <= s_ready_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (hs) state_d = ST_LEN_LO;
      ST_LEN_LO:  if (hs) state_d = ST_CHECK;
      ST_CHECK: begin
        if (ovf)                state_d = ST_FIN;
        else if (cnt_q == '0)   state_d = ST_AFTER_DATA;
        else                    state_d = ST_DATA_HI;
      end
      ST_DATA_HI: if (hs) state_d = ST_DATA_LO;
      ST_DATA_LO: if (hs) state_d = (cnt_q == 16'd1) ? ST_AFTER_DATA : ST_DATA_HI;
`ifdef RAM_LOADER_CSUM_EN
      ST_CSUM_HI: if (hs) state_d = ST_CSUM_LO;
      ST_CSUM_LO: if (hs) state_d = ST_FIN;
`endif
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    error_d    = error_q;
    // Registered ready tracks the state being entered, so it lines up with state_q.
    s_ready_d  = rx_state(state_d);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          waddr_d = base_addr;
          busy_d  = 1'b1;
          error_d = 1'b0;
        end
      end
      ST_LEN_HI, ST_DATA_HI, ST_CSUM_HI: begin
        if (hs) byte_d = s_data;
      end
      ST_LEN_LO: begin
        if (hs) cnt_d = {byte_q, s_data};
      end
      ST_CHECK: begin
        if (ovf) error_d = 1'b1;
      end
      ST_DATA_LO: begin
        if (hs) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = waddr_q;
          ram_din_d  = word;
          waddr_d    = waddr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end
      end
`ifdef RAM_LOADER_CSUM_EN
      ST_CSUM_LO: begin
        if (hs && csum_bad) error_d = 1'b1;
      end
`endif
      ST_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign s_ready  = s_ready_q;
  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: randomized byte streams against a word-level load model.
module tb_ram_loader;

  localparam int ADDR  = 15;
  localparam int NEVER = 1 << 30;
`ifdef RAM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ADDR-1:0] base_addr = '0;
  logic            s_valid = 1'b0;
  logic [7:0]      s_data = '0;
  logic            s_ready;
  logic            ram_wr;
  logic [ADDR-1:0] ram_addr;
  logic [15:0]     ram_din;
  logic            busy;
  logic            done;
  logic            error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [ADDR-1:0] w_addr[$];
  logic [15:0]     w_data[$];
  int              w_cyc[$];
  int              dbl = 0;
  int              done_cnt = 0;
  int              done_cyc = 0;
  logic            prev_wr = 1'b0;
  logic            busy_at_done = 1'b0;
  logic            err_at_done = 1'b0;
  logic            busy_first = 1'b0;
  logic            rdy_first = 1'b0;

  ram_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_wr) begin
      w_addr.push_back(ram_addr);
      w_data.push_back(ram_din);
      w_cyc.push_back(cyc);
    end
    if (ram_wr && prev_wr) dbl++;
    prev_wr = ram_wr;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
      err_at_done  = error;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Model helpers: what a correct load must produce.
  function automatic bit model_ovf(input logic [ADDR-1:0] base, input logic [15:0] n);
    return (int'(base) + int'(n)) > (1 << ADDR);
  endfunction

  function automatic logic [15:0] model_sum(input logic [15:0] words[$]);
    logic [15:0] s = '0;
    foreach (words[k]) s = s + words[k];
    return s;
  endfunction

  task automatic run_load(input logic [ADDR-1:0] base, input logic [15:0] n,
                          input logic [15:0] words[$], input logic [15:0] csum_delta,
                          input bit hdr_only, input bit gaps, input bit poke,
                          input int stop_after, output int start_cyc, output bit tmo);
    logic [7:0]  bytes[$];
    logic [15:0] cs;
    int idx;
    int guard;
    bytes = {};
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    if (!hdr_only) begin
      foreach (words[k]) begin
        bytes.push_back(words[k][15:8]);
        bytes.push_back(words[k][7:0]);
      end
      if (CSUM) begin
        cs = model_sum(words) + csum_delta;
        bytes.push_back(cs[15:8]);
        bytes.push_back(cs[7:0]);
      end
    end
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    dbl = 0;
    done_cnt = 0;
    tmo = 1'b0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    busy_first = busy;
    rdy_first = s_ready;
    idx = 0;
    guard = 0;
    while (idx < bytes.size() && w_addr.size() < stop_after) begin
      if (guard > 2000) begin
        tmo = 1'b1;
        break;
      end
      guard++;
      start   = poke && (idx == 3);
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = bytes[idx];
      if (s_valid && s_ready) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (stop_after == NEVER) begin
      for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge clk);
      if (done_cnt == 0) tmo = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({s_ready, ram_wr, ram_addr, ram_din, busy, done, error} !== '0) begin
      fails++;
      $display("FAIL reset_values: got %b, want all zero",
               {s_ready, ram_wr, ram_addr, ram_din, busy, done, error});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({s_ready, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b, want 000", {s_ready, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [15:0] words[$] = '{16'h1234, 16'hABCD, 16'h0001};
    int sc;
    bit tmo;
    int extra;
    extra = CSUM ? 2 : 0;
    run_load(15'h0100, 16'd3, words, 16'd0, 1'b0, 1'b0, 1'b0, NEVER, sc, tmo);
    tests++;
    if (tmo) begin fails++; $display("FAIL basic_timeout: load did not finish"); end
    tests++;
    if ({busy_first, rdy_first} !== 2'b11) begin
      fails++;
      $display("FAIL basic_start_resp: busy,s_ready=%b want 11", {busy_first, rdy_first});
    end
    tests++;
    if (w_addr.size() != 3) begin
      fails++;
      $display("FAIL basic_write_count: got %0d want 3", w_addr.size());
    end
    for (int k = 0; k < 3 && k < w_addr.size(); k++) begin
      logic [ADDR-1:0] ea;
      ea = 15'h0100 + ADDR'(k);
      tests++;
      if (w_addr[k] !== ea) begin
        fails++;
        $display("FAIL basic_addr[%0d]: got %h want %h", k, w_addr[k], ea);
      end
      tests++;
      if (w_data[k] !== words[k]) begin
        fails++;
        $display("FAIL basic_data[%0d]: got %h want %h", k, w_data[k], words[k]);
      end
      tests++;
      if (w_cyc[k] != sc + 5 + 2 * k) begin
        fails++;
        $display("FAIL basic_wr_cycle[%0d]: got %0d want %0d", k, w_cyc[k] - sc, 5 + 2 * k);
      end
    end
    tests++;
    if (done_cyc != sc + 2 * 3 + 4 + extra) begin
      fails++;
      $display("FAIL basic_latency: got %0d want %0d", done_cyc - sc, 2 * 3 + 4 + extra);
    end
    tests++;
    if ({err_at_done, busy_at_done} !== 2'b00) begin
      fails++;
      $display("FAIL basic_done_state: error,busy=%b want 00", {err_at_done, busy_at_done});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_single_done: done pulses=%0d busy=%b want 1,0", done_cnt, busy);
    end
  endtask

  task automatic test_zero_len();
    logic [15:0] words[$];
    int sc;
    bit tmo;
    words = {};
    run_load(15'h0200, 16'd0, words, 16'd0, 1'b0, 1'b0, 1'b0, NEVER, sc, tmo);
    tests++;
    if (tmo || w_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_writes: timeout=%0d writes=%0d want 0,0", tmo, w_addr.size());
    end
    tests++;
    if (done_cyc != sc + 4 + (CSUM ? 2 : 0)) begin
      fails++;
      $display("FAIL zero_latency: got %0d want %0d", done_cyc - sc, 4 + (CSUM ? 2 : 0));
    end
    tests++;
    if ({err_at_done, busy_at_done} !== 2'b00) begin
      fails++;
      $display("FAIL zero_done_state: error,busy=%b want 00", {err_at_done, busy_at_done});
    end
  endtask

  task automatic test_overflow();
    logic [15:0] words[$];
    int sc;
    bit tmo;
    int rdy_seen;
    words = {};
    run_load(15'h7FFE, 16'd3, words, 16'd0, 1'b1, 1'b0, 1'b0, NEVER, sc, tmo);
    tests++;
    if (tmo || w_addr.size() != 0) begin
      fails++;
      $display("FAIL ovf_writes: timeout=%0d writes=%0d want 0,0", tmo, w_addr.size());
    end
    tests++;
    if ({err_at_done, busy_at_done} !== 2'b10) begin
      fails++;
      $display("FAIL ovf_done_state: error,busy=%b want 10", {err_at_done, busy_at_done});
    end
    tests++;
    if (done_cyc != sc + 4) begin
      fails++;
      $display("FAIL ovf_latency: got %0d want 4", done_cyc - sc);
    end
    rdy_seen = 0;
    s_valid = 1'b1;
    s_data = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_ready) rdy_seen++;
    end
    s_valid = 1'b0;
    tests++;
    if (rdy_seen != 0 || error !== 1'b1 || done_cnt != 1) begin
      fails++;
      $display("FAIL ovf_after: s_ready cycles=%0d error=%b done pulses=%0d want 0,1,1",
               rdy_seen, error, done_cnt);
    end
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 10; r++) begin
      logic [15:0]     words[$];
      logic [ADDR-1:0] base;
      logic [15:0]     n;
      bit              ovf;
      bit              tmo;
      int              sc;
      int              nexp;
      words = {};
      case (r)
        0: begin base = 15'h0100; words = '{16'h1234, 16'hABCD, 16'h0001}; n = 16'd3; end
        1: begin base = 15'h7FFD; n = 16'd3; end
        2: begin base = 15'h7FFD; n = 16'd4; end
        default: begin
          base = (r % 2 == 1) ? ADDR'(32767 - $urandom_range(0, 8)) : ADDR'($urandom_range(0, 32767));
          n = 16'($urandom_range(0, 6));
        end
      endcase
      if (r != 0) for (int k = 0; k < int'(n); k++) words.push_back(16'($urandom));
      ovf = model_ovf(base, n);
      nexp = ovf ? 0 : int'(n);
      run_load(base, n, words, 16'd0, ovf, 1'b1, (r >= 3), NEVER, sc, tmo);
      tests++;
      if (tmo || w_addr.size() != nexp) begin
        fails++;
        $display("FAIL rand%0d_count: timeout=%0d writes=%0d want 0,%0d", r, tmo, w_addr.size(), nexp);
      end
      for (int k = 0; k < nexp && k < w_addr.size(); k++) begin
        logic [ADDR-1:0] ea;
        ea = base + ADDR'(k);
        tests++;
        if (w_addr[k] !== ea || w_data[k] !== words[k]) begin
          fails++;
          $display("FAIL rand%0d_write[%0d]: got %h/%h want %h/%h", r, k, w_addr[k], w_data[k], ea, words[k]);
        end
      end
      tests++;
      if (err_at_done !== ovf || busy_at_done !== 1'b0 || dbl != 0 || done_cnt != 1) begin
        fails++;
        $display("FAIL rand%0d_status: error=%b busy=%b dbl=%0d done=%0d want %b,0,0,1",
                 r, err_at_done, busy_at_done, dbl, done_cnt, ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] words[$] = '{16'h1234, 16'hABCD, 16'h0001};
    int sc;
    bit tmo;
    logic busy_before;
    run_load(15'h0100, 16'd3, words, 16'd0, 1'b0, 1'b0, 1'b0, 2, sc, tmo);
    busy_before = busy;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (busy_before !== 1'b1 || {s_ready, ram_wr, ram_addr, ram_din, busy, done, error} !== '0) begin
      fails++;
      $display("FAIL midreset_async: busy_before=%b outputs=%b want 1 then all zero", busy_before,
               {s_ready, ram_wr, ram_addr, ram_din, busy, done, error});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (w_addr.size() != 2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_writes: writes=%0d busy=%b want 2,0", w_addr.size(), busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_load(15'h0300, 16'd3, words, 16'd0, 1'b0, 1'b0, 1'b0, NEVER, sc, tmo);
    tests++;
    if (tmo || w_addr.size() != 3 || err_at_done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_reload: timeout=%0d writes=%0d error=%b want 0,3,0", tmo, w_addr.size(), err_at_done);
    end
    for (int k = 0; k < 3 && k < w_addr.size(); k++) begin
      tests++;
      if (w_addr[k] !== 15'h0300 + ADDR'(k) || w_data[k] !== words[k]) begin
        fails++;
        $display("FAIL midreset_reload_write[%0d]: got %h/%h want %h/%h", k, w_addr[k], w_data[k],
                 15'h0300 + ADDR'(k), words[k]);
      end
    end
  endtask

`ifdef RAM_LOADER_CSUM_EN
  task automatic test_csum();
    logic [15:0] words[$] = '{16'h0001, 16'h0002};
    int sc;
    bit tmo;
    for (int d = 0; d < 2; d++) begin
      run_load(15'h0040, 16'd2, words, 16'(d), 1'b0, 1'b1, 1'b0, NEVER, sc, tmo);
      tests++;
      if (tmo || w_addr.size() != 2 || err_at_done !== 1'(d)) begin
        fails++;
        $display("FAIL csum%0d: timeout=%0d writes=%0d error=%b want 0,2,%0d", d, tmo, w_addr.size(), err_at_done, d);
      end
      for (int k = 0; k < 2 && k < w_addr.size(); k++) begin
        tests++;
        if (w_addr[k] !== 15'h0040 + ADDR'(k) || w_data[k] !== words[k]) begin
          fails++;
          $display("FAIL csum%0d_write[%0d]: got %h/%h want %h/%h", d, k, w_addr[k], w_data[k],
                   15'h0040 + ADDR'(k), words[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_random_loads();
    test_reset_mid();
`ifdef RAM_LOADER_CSUM_EN
    test_csum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
